// File: rtl/adap_quan_mc.sv
// rtl/adap_quan_mc.sv - multi-channel G.726 adaptive quantizer, 3-stage stallable pipeline
module adap_quan_mc #(
    parameter int CHW = 2,
    parameter int DW  = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           scan_in0,
    input  logic           scan_en,
    output logic           scan_out0,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CHW-1:0] in_ch,
    input  logic [DW-1:0]  in_d,
    input  logic [12:0]    in_y,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [1:0]     cfg_rate,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CHW-1:0] out_ch,
    output logic [4:0]     out_i
);
    localparam int NCH = 2 ** CHW;

    // G.726 decision levels in the log domain, ascending
    localparam logic signed [11:0] T16 [1]  = '{12'sd261};
    localparam logic signed [11:0] T24 [3]  = '{12'sd8, 12'sd218, 12'sd331};
    localparam logic signed [11:0] T32 [7]  = '{-12'sd124, 12'sd80, 12'sd178, 12'sd246,
                                                12'sd300, 12'sd349, 12'sd400};
    localparam logic signed [11:0] T40 [15] = '{-12'sd122, -12'sd16, 12'sd68, 12'sd139,
                                                12'sd198, 12'sd250, 12'sd298, 12'sd339,
                                                12'sd378, 12'sd413, 12'sd445, 12'sd475,
                                                12'sd502, 12'sd528, 12'sd553};

    logic [1:0]     rate_q [NCH];
    logic [1:0]     rate_d [NCH];
    logic           scan_q, scan_d;

    logic           s1_valid_q, s1_valid_d;
    logic [CHW-1:0] s1_ch_q, s1_ch_d;
    logic           s1_ds_q, s1_ds_d;
    logic [14:0]    s1_dqm_q, s1_dqm_d;
    logic [10:0]    s1_y_q, s1_y_d;
    logic [1:0]     s1_rate_q, s1_rate_d;

    logic           s2_valid_q, s2_valid_d;
    logic [CHW-1:0] s2_ch_q, s2_ch_d;
    logic           s2_ds_q, s2_ds_d;
    logic [11:0]    s2_dln_q, s2_dln_d;
    logic [1:0]     s2_rate_q, s2_rate_d;

    logic           out_valid_q, out_valid_d;
    logic [CHW-1:0] out_ch_q, out_ch_d;
    logic [4:0]     out_i_q, out_i_d;

    logic           adv;
    logic [15:0]    neg_d;
    logic [3:0]     exp_c;
    logic [6:0]     mant_c;
    logic [10:0]    dl_c;
    logic [4:0]     mag_c;
    logic [4:0]     max_c;

    // the whole pipeline moves as one; a stalled, full output freezes every stage
    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_i     = out_i_q;
    assign scan_out0 = scan_q;

    // rate table writes land at the clock edge, so a same-cycle sample still reads the old rate
    always_comb begin
        rate_d = rate_q;
        if (cfg_we) rate_d[cfg_ch] = cfg_rate;
        scan_d = scan_en ? scan_in0 : scan_q;
    end

    // S1: sign/magnitude split and rate capture
    always_comb begin
        neg_d      = 16'(~in_d[15:0] + 16'd1);
        s1_valid_d = s1_valid_q;
        s1_ch_d    = s1_ch_q;
        s1_ds_d    = s1_ds_q;
        s1_dqm_d   = s1_dqm_q;
        s1_y_d     = s1_y_q;
        s1_rate_d  = s1_rate_q;
        if (adv) begin
            s1_valid_d = in_valid;
            s1_ch_d    = in_ch;
            s1_ds_d    = in_d[DW-1];
            s1_dqm_d   = in_d[DW-1] ? neg_d[14:0] : in_d[14:0];
            s1_y_d     = in_y[12:2];
            s1_rate_d  = rate_q[in_ch];
        end
    end

    // S2: log2 conversion of the magnitude and normalisation by the scale factor
    always_comb begin
        exp_c = 4'd0;
        for (int b = 0; b < 15; b++) begin
            if (s1_dqm_q[b]) exp_c = 4'(b);
        end
        mant_c     = 7'({s1_dqm_q, 7'd0} >> exp_c);
        dl_c       = {exp_c, mant_c};
        s2_valid_d = s2_valid_q;
        s2_ch_d    = s2_ch_q;
        s2_ds_d    = s2_ds_q;
        s2_dln_d   = s2_dln_q;
        s2_rate_d  = s2_rate_q;
        if (adv) begin
            s2_valid_d = s1_valid_q;
            s2_ch_d    = s1_ch_q;
            s2_ds_d    = s1_ds_q;
            s2_dln_d   = {1'b0, dl_c} - {1'b0, s1_y_q};
            s2_rate_d  = s1_rate_q;
        end
    end

    // S3: table lookup; the highest level not above DLN gives the magnitude
    always_comb begin
        mag_c = 5'd0;
        max_c = 5'd15;
        case (s2_rate_q)
            2'd0: begin
                max_c = 5'd3;
                if ($signed(s2_dln_q) >= T16[0]) mag_c = 5'd1;
            end
            2'd1: begin
                max_c = 5'd7;
                for (int k = 0; k < 3; k++)
                    if ($signed(s2_dln_q) >= T24[k]) mag_c = 5'(k + 1);
            end
            2'd2: begin
                max_c = 5'd15;
                for (int k = 0; k < 7; k++)
                    if ($signed(s2_dln_q) >= T32[k]) mag_c = 5'(k + 1);
            end
            default: begin
                max_c = 5'd31;
                for (int k = 0; k < 15; k++)
                    if ($signed(s2_dln_q) >= T40[k]) mag_c = 5'(k + 1);
            end
        endcase
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_i_d     = out_i_q;
        if (adv) begin
            out_valid_d = s2_valid_q;
            out_ch_d    = s2_ch_q;
            if (s2_ds_q)            out_i_d = max_c - mag_c;
            else if (mag_c == 5'd0) out_i_d = max_c;
            else                    out_i_d = mag_c;
        end
    end

    // state registers; reset drops everything in flight and restores 32k on all channels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) rate_q[c] <= 2'd2;
            scan_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_ds_q     <= 1'b0;
            s1_dqm_q    <= '0;
            s1_y_q      <= '0;
            s1_rate_q   <= 2'd2;
            s2_valid_q  <= 1'b0;
            s2_ch_q     <= '0;
            s2_ds_q     <= 1'b0;
            s2_dln_q    <= '0;
            s2_rate_q   <= 2'd2;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_i_q     <= '0;
        end else begin
            rate_q      <= rate_d;
            scan_q      <= scan_d;
            s1_valid_q  <= s1_valid_d;
            s1_ch_q     <= s1_ch_d;
            s1_ds_q     <= s1_ds_d;
            s1_dqm_q    <= s1_dqm_d;
            s1_y_q      <= s1_y_d;
            s1_rate_q   <= s1_rate_d;
            s2_valid_q  <= s2_valid_d;
            s2_ch_q     <= s2_ch_d;
            s2_ds_q     <= s2_ds_d;
            s2_dln_q    <= s2_dln_d;
            s2_rate_q   <= s2_rate_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_i_q     <= out_i_d;
        end
    end
endmodule

// File: tb/tb_adap_quan_mc.sv
// tb/tb_adap_quan_mc.sv - scoreboard bench for adap_quan_mc
module tb_adap_quan_mc;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scan_in0 = 1'b0;
    logic       scan_en = 1'b0;
    logic       scan_out0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_ch = '0;
    logic [15:0] in_d = '0;
    logic [12:0] in_y = '0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [1:0] cfg_rate = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [1:0] out_ch;
    logic [4:0] out_i;

    typedef struct {
        int ch;
        int code;
        int acyc;
    } exp_t;

    exp_t sbq[$];
    int   tb_rate [4] = '{2, 2, 2, 2};
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    bit   rnd_ready = 1'b0;
    bit   lat_mode = 1'b1;
    bit   prev_stall = 1'b0;
    int   prev_ch = 0;
    int   prev_i = 0;

    adap_quan_mc #(.CHW(2), .DW(16)) dut (
        .clk(clk), .reset(reset), .scan_in0(scan_in0), .scan_en(scan_en),
        .scan_out0(scan_out0), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .in_d(in_d), .in_y(in_y), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_rate(cfg_rate), .out_valid(out_valid),
        .out_ready(out_ready), .out_ch(out_ch), .out_i(out_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    endtask

    // reference quantizer written straight from the G.726 description
    function automatic int model(input int d, input int y, input int rate);
        int ds, dqm, e, mant, dl, dln, n, mag, mx;
        int th [15];
        ds  = (d >> 15) & 1;
        dqm = ds ? ((65536 - d) & 32767) : d;
        e   = 0;
        for (int b = 0; b < 15; b++) if (((dqm >> b) & 1) == 1) e = b;
        mant = ((dqm << 7) >> e) & 127;
        dl   = e * 128 + mant;
        dln  = dl - (y >> 2);
        for (int k = 0; k < 15; k++) th[k] = 0;
        case (rate)
            0: begin n = 1; th[0] = 261; end
            1: begin n = 3; th[0] = 8; th[1] = 218; th[2] = 331; end
            2: begin
                n = 7;
                th[0] = -124; th[1] = 80; th[2] = 178; th[3] = 246;
                th[4] = 300; th[5] = 349; th[6] = 400;
            end
            default: begin
                n = 15;
                th[0] = -122; th[1] = -16; th[2] = 68; th[3] = 139; th[4] = 198;
                th[5] = 250; th[6] = 298; th[7] = 339; th[8] = 378; th[9] = 413;
                th[10] = 445; th[11] = 475; th[12] = 502; th[13] = 528; th[14] = 553;
            end
        endcase
        mag = 0;
        for (int k = 0; k < n; k++) if (dln >= th[k]) mag++;
        mx = (1 << (rate + 2)) - 1;
        if (ds == 1) return mx - mag;
        if (mag == 0) return mx;
        return mag;
    endfunction

    task automatic send(input int ch, input int d, input int y, input bit we,
                        input int wch, input int wrate, input int exp_o);
        exp_t e;
        bit   acc;
        acc = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_ch    = 2'(ch);
        in_d     = 16'(d);
        in_y     = 13'(y);
        cfg_we   = we;
        cfg_ch   = 2'(wch);
        cfg_rate = 2'(wrate);
        for (int t = 0; t < 100; t++) begin
            #1;
            if (in_ready) begin
                e.ch   = ch;
                e.code = (exp_o >= 0) ? exp_o : model(d, y, tb_rate[ch]);
                e.acyc = cyc;
                sbq.push_back(e);
                acc = 1'b1;
            end
            if (cfg_we) tb_rate[cfg_ch] = int'(cfg_rate);
            if (acc) break;
            @(negedge clk);
            cfg_we = 1'b0;
        end
        if (!acc) chk("send_tmo", int'(in_ready), 1);
    endtask

    task automatic cfg_write(input int ch, input int rate);
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_rate = 2'(rate);
        tb_rate[ch] = rate;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we   = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int t = 0; t < 300; t++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", sbq.size(), 0);
    endtask

    // output side: pop on handshake, verify stability while stalled
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!reset) begin
            if (prev_stall) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_ch", int'(out_ch), prev_ch);
                chk("stall_i", int'(out_i), prev_i);
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexp_out", int'(out_valid), 0);
                end else begin
                    e = sbq.pop_front();
                    chk("out_ch", int'(out_ch), e.ch);
                    chk("out_i", int'(out_i), e.code);
                    if (lat_mode) chk("latency", cyc - e.acyc, 3);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_ch    = int'(out_ch);
            prev_i     = int'(out_i);
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_i", int'(out_i), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        #21;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        // directed 32k vectors, then a same-cycle rate change on channel 1
        send(0, 'h0100, 'h0400, 1'b0, 0, 0, 7);
        send(1, 'hFF00, 'h0400, 1'b0, 0, 0, 8);
        send(2, 'h0000, 2048, 1'b0, 0, 0, 15);
        send(1, 'hFF00, 'h0400, 1'b1, 1, 3, 8);
        send(1, 'hFF00, 'h0400, 1'b0, 0, 0, 16);
        cfg_write(0, 0);
        send(0, 'h0000, 0, 1'b0, 0, 0, 3);
        cfg_write(3, 1);
        send(3, 'h0000, 0, 1'b0, 0, 0, 7);
        send(3, 'h8000, 0, 1'b0, 0, 0, -1);
        drain();

        // random traffic with backpressure and occasional rate writes
        lat_mode  = 1'b0;
        rnd_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) idle();
            else send($urandom_range(0, 3), $urandom_range(0, 65535), $urandom_range(0, 8191),
                      1'($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end
        drain();
        rnd_ready = 1'b0;
        idle();
        idle();
        lat_mode = 1'b1;

        // reset with three samples in flight
        cfg_write(2, 0);
        cfg_write(1, 3);
        send(0, 'h0100, 'h0400, 1'b0, 0, 0, -1);
        send(1, 'h0100, 'h0400, 1'b0, 0, 0, -1);
        send(2, 'h0100, 'h0400, 1'b0, 0, 0, -1);
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("inrst_out_valid", int'(out_valid), 0);
        chk("inrst_out_i", int'(out_i), 0);
        chk("inrst_in_ready", int'(in_ready), 1);
        sbq.delete();
        for (int c = 0; c < 4; c++) tb_rate[c] = 2;
        @(negedge clk);
        #2;
        reset = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            #1;
            chk("no_stale", int'(out_valid), 0);
        end
        send(0, 'h0100, 'h0400, 1'b0, 0, 0, 7);
        send(1, 'h0100, 'h0400, 1'b0, 0, 0, 7);
        send(2, 'h0100, 'h0400, 1'b0, 0, 0, 7);
        send(3, 'h0100, 'h0400, 1'b0, 0, 0, 7);
        send(1, 'hFF00, 'h0400, 1'b0, 0, 0, 8);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
